// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: step states, opcode
// values, instruction classes, ALU operation codes and the packed strobe bundle.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU is driven with the instruction's own opcode value.
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = OP_ADD;
    localparam logic [4:0] ALU_SUB  = OP_SUB;
    localparam logic [4:0] ALU_AND  = OP_AND;
    localparam logic [4:0] ALU_OR   = OP_OR;
    localparam logic [4:0] ALU_SHR  = OP_SHR;
    localparam logic [4:0] ALU_SHRA = OP_SHRA;
    localparam logic [4:0] ALU_SHL  = OP_SHL;
    localparam logic [4:0] ALU_ROR  = OP_ROR;
    localparam logic [4:0] ALU_ROL  = OP_ROL;
    localparam logic [4:0] ALU_MUL  = OP_MUL;
    localparam logic [4:0] ALU_DIV  = OP_DIV;
    localparam logic [4:0] ALU_NEG  = OP_NEG;
    localparam logic [4:0] ALU_NOT  = OP_NOT;

    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       inc_pc;
        logic       read;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       zlo_out;
        logic       zhi_out;
        logic       lo_in;
        logic       hi_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [4:0] alu;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    function automatic logic [4:0] alu_code(input logic [4:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHRA: return ALU_SHRA;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects the execute-step
// sequence; anything not explicitly listed is treated as a no-op.
module opcode_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_ALU3;
            OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
            OP_HALT:                         op_class = CLS_HALT;
            default:                         op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer: one step per clock, with strobes registered
// so that each output flop holds the decode of the state it accompanies.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        IncrementPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  ALUControl,
    output logic        InstrDone,
    output logic        Halted
);

    state_e    state_q, state_d;
    logic [4:0] op_q, op_d;
    ctrl_t     ctrl_q, ctrl_d;
    op_class_e op_class;
    logic      unused_ir;

    // Only the opcode field steers sequencing; operand fields are decoded elsewhere.
    assign unused_ir = ^IR[26:0];

    // The opcode is captured on the edge that leaves T2; until then the live IR
    // is decoded so the T3 strobes are ready on that same edge.
    assign op_d = (state_q == S_T2) ? IR[31:27] : op_q;

    opcode_class_decode u_class_decode (
        .opcode   (op_d),
        .op_class (op_class)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (op_class)
                    CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_d = S_T4;
                    CLS_HALT:                        state_d = S_HALT;
                    default:                         state_d = Run ? S_T0 : S_IDLE;
                endcase
            end
            S_T4: begin
                if (op_class == CLS_ALU3 || op_class == CLS_MULDIV) state_d = S_T5;
                else                                                state_d = Run ? S_T0 : S_IDLE;
            end
            S_T5: begin
                if (op_class == CLS_MULDIV) state_d = S_T6;
                else                        state_d = Run ? S_T0 : S_IDLE;
            end
            S_T6:   state_d = Run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: defaulting the whole bundle first keeps this block free of latches.
        ctrl_d = '0;
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_d.zlo_out = 1'b1;
                ctrl_d.pc_in   = 1'b1;
                ctrl_d.read    = 1'b1;
                ctrl_d.mdr_in  = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU3: begin
                        ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                        ctrl_d.alu = alu_code(op_d);
                    end
                    default: ctrl_d.instr_done = 1'b1;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU3: begin
                        ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                        ctrl_d.alu = alu_code(op_d);
                    end
                    CLS_MULDIV: begin
                        ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1;
                        ctrl_d.alu = alu_code(op_d);
                    end
                    default: begin
                        ctrl_d.zlo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1;
                        ctrl_d.instr_done = 1'b1;
                    end
                endcase
            end
            S_T5: begin
                if (op_class == CLS_MULDIV) begin
                    ctrl_d.zlo_out = 1'b1; ctrl_d.lo_in = 1'b1;
                end else begin
                    ctrl_d.zlo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1;
                    ctrl_d.instr_done = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d.zhi_out    = 1'b1;
                ctrl_d.hi_in      = 1'b1;
                ctrl_d.instr_done = 1'b1;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    assign PCout       = ctrl_q.pc_out;
    assign MARin       = ctrl_q.mar_in;
    assign Zin         = ctrl_q.z_in;
    assign PCin        = ctrl_q.pc_in;
    assign IncrementPC = ctrl_q.inc_pc;
    assign Read        = ctrl_q.read;
    assign MDRin       = ctrl_q.mdr_in;
    assign MDRout      = ctrl_q.mdr_out;
    assign IRin        = ctrl_q.ir_in;
    assign Yin         = ctrl_q.y_in;
    assign ZLOout      = ctrl_q.zlo_out;
    assign ZHIout      = ctrl_q.zhi_out;
    assign LOin        = ctrl_q.lo_in;
    assign HIin        = ctrl_q.hi_in;
    assign Gra         = ctrl_q.gra;
    assign Grb         = ctrl_q.grb;
    assign Grc         = ctrl_q.grc;
    assign Rin         = ctrl_q.r_in;
    assign Rout        = ctrl_q.r_out;
    assign ALUControl  = ctrl_q.alu;
    assign InstrDone   = ctrl_q.instr_done;
    assign Halted      = ctrl_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random instruction
// streams, each step compared against a step-table model of the instruction set.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Run;
    logic [31:0] IR;
    logic PCout, MARin, Zin, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin;
    logic ZLOout, ZHIout, LOin, HIin, Gra, Grb, Grc, Rin, Rout, InstrDone, Halted;
    logic [4:0]  ALUControl;

    int checks = 0;
    int errors = 0;

    localparam int P_PCOUT = 25, P_MARIN = 24, P_ZIN = 23, P_PCIN = 22, P_INCPC = 21;
    localparam int P_READ = 20, P_MDRIN = 19, P_MDROUT = 18, P_IRIN = 17, P_YIN = 16;
    localparam int P_ZLO = 15, P_ZHI = 14, P_LOIN = 13, P_HIIN = 12, P_GRA = 11;
    localparam int P_GRB = 10, P_GRC = 9, P_RIN = 8, P_ROUT = 7, P_DONE = 1, P_HALTED = 0;

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .IR(IR),
        .PCout(PCout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .IncrementPC(IncrementPC),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .ZLOout(ZLOout), .ZHIout(ZHIout), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .ALUControl(ALUControl), .InstrDone(InstrDone), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    logic [25:0] obs;
    assign obs = {PCout, MARin, Zin, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin,
                  ZLOout, ZHIout, LOin, HIin, Gra, Grb, Grc, Rin, Rout,
                  ALUControl, InstrDone, Halted};

    // Instruction kinds: 0 three-operand ALU, 1 mul/div, 2 unary, 3 no-op, 4 halt.
    function automatic int kind_of(input logic [4:0] op);
        int v = int'(op);
        if (v >= 3 && v <= 11)      return 0;
        if (v == 15 || v == 16)     return 1;
        if (v == 17 || v == 18)     return 2;
        if (v == 27)                return 4;
        return 3;
    endfunction

    function automatic int instr_len(input logic [4:0] op);
        case (kind_of(op))
            0:       return 6;
            1:       return 7;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    // Expected output vector for step k (0 = T0) of an instruction with opcode op.
    function automatic logic [25:0] expect_step(input logic [4:0] op, input int k);
        logic [25:0] e = '0;
        int kind = kind_of(op);
        int x = k - 3;
        if (k == 0) begin
            e[P_PCOUT] = 1; e[P_MARIN] = 1; e[P_INCPC] = 1; e[P_ZIN] = 1;
        end else if (k == 1) begin
            e[P_ZLO] = 1; e[P_PCIN] = 1; e[P_READ] = 1; e[P_MDRIN] = 1;
        end else if (k == 2) begin
            e[P_MDROUT] = 1; e[P_IRIN] = 1;
        end else if (kind == 0) begin
            if (x == 0) begin e[P_GRB] = 1; e[P_ROUT] = 1; e[P_YIN] = 1; end
            if (x == 1) begin e[P_GRC] = 1; e[P_ROUT] = 1; e[P_ZIN] = 1; e[6:2] = op; end
            if (x == 2) begin e[P_ZLO] = 1; e[P_GRA] = 1; e[P_RIN] = 1; e[P_DONE] = 1; end
        end else if (kind == 1) begin
            if (x == 0) begin e[P_GRA] = 1; e[P_ROUT] = 1; e[P_YIN] = 1; end
            if (x == 1) begin e[P_GRB] = 1; e[P_ROUT] = 1; e[P_ZIN] = 1; e[6:2] = op; end
            if (x == 2) begin e[P_ZLO] = 1; e[P_LOIN] = 1; end
            if (x == 3) begin e[P_ZHI] = 1; e[P_HIIN] = 1; e[P_DONE] = 1; end
        end else if (kind == 2) begin
            if (x == 0) begin e[P_GRB] = 1; e[P_ROUT] = 1; e[P_ZIN] = 1; e[6:2] = op; end
            if (x == 1) begin e[P_ZLO] = 1; e[P_GRA] = 1; e[P_RIN] = 1; e[P_DONE] = 1; end
        end else begin
            e[P_DONE] = 1;
        end
        return e;
    endfunction

    task automatic check_vec(input logic [25:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rules(input string tag);
        checks++;
        assert (!(Rin && Rout) && !(Zin && (ZLOout || ZHIout))) else begin
            errors++;
            $error("FAIL %s exclusivity: observed %h expected no Rin/Rout or Zin/Z-out overlap",
                   tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Runs up to n_steps steps of one instruction. Run is forced high on the edge
    // that starts it, low from step drop_from onward, random in between if rnd_run.
    task automatic run_instr(input logic [31:0] ir, input int drop_from,
                             input bit rnd_run, input int n_steps);
        logic [4:0] op = ir[31:27];
        int len = instr_len(op);
        if (n_steps < len) len = n_steps;
        for (int k = 0; k < len; k++) begin
            if (k == 0)              Run = 1'b1;
            else if (k >= drop_from) Run = 1'b0;
            else if (rnd_run)        Run = 1'($urandom_range(0, 1));
            else                     Run = 1'b1;
            IR = (k == 3) ? ir : $urandom;
            tick();
            check_vec(expect_step(op, k), $sformatf("op%0d_step%0d", op, k));
            check_rules($sformatf("op%0d_step%0d", op, k));
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Run     = 1'b0;
        IR      = '0;
        repeat (2) tick();
        check_vec('0, "reset_state");
        Run = 1'b1;
        tick();
        check_vec('0, "reset_holds_with_run");
        @(negedge Clock);
        Reset_n = 1'b1;

        // and R1,R2,R3: six steps, ALU code on T4, writeback and done on T5
        run_instr(32'h28918000, 99, 1'b0, 99);
        run_instr({5'b01111, 27'h0123456}, 99, 1'b0, 99);
        run_instr({5'b10010, 27'h0654321}, 99, 1'b0, 99);
        // Run dropped during T3 of an add: finishes, then idles
        run_instr({5'b00011, 27'h0111111}, 4, 1'b0, 99);
        tick();
        check_vec('0, "idle_after_drop");
        repeat (3) begin
            IR = $urandom;
            tick();
            check_vec('0, "idle_stays");
        end

        for (int n = 0; n < 40; n++) begin
            logic [31:0] r = $urandom;
            if (r[31:27] == 5'b11011) r[31:27] = 5'b11010;
            run_instr(r, 99, 1'b1, 99);
            if ($urandom_range(0, 3) == 0) begin
                Run = 1'b0;
                tick();
                check_vec('0, "idle_between");
            end
        end

        // Reset in T4 clears outputs without waiting for a clock
        run_instr({5'b00100, 27'h0222222}, 99, 1'b0, 5);
        #3 Reset_n = 1'b0;
        #1 check_vec('0, "async_reset_mid_instr");
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        run_instr({5'b10000, 27'h0333333}, 99, 1'b0, 99);

        run_instr({5'b11011, 27'h0444444}, 99, 1'b0, 99);
        repeat (6) begin
            Run = 1'($urandom_range(0, 1));
            IR  = $urandom;
            tick();
            check_vec(26'd1, "halted_holds");
        end
        #2 Reset_n = 1'b0;
        #1 check_vec('0, "reset_clears_halt");
        Run = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        check_vec('0, "idle_after_halt_reset");
        run_instr({5'b00000, 27'h0555555}, 99, 1'b0, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
